// File: rtl/dff_pipeline.sv
// Elastic register pipeline: DEPTH valid/data stages with per-stage ready,
// bubble collapse, flush and a registered occupancy counter.
module dff_pipeline #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] prev_v;
    logic [WIDTH-1:0] prev_d [DEPTH];
    logic             in_fire;
    logic             out_fire;

    // Ready chain evaluated top-down through one accumulator so the
    // r[i] -> r[i-1] dependency stays inside a single process.
    always_comb begin : ready_chain
        logic acc;
        acc = out_ready;
        r   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            acc              = !v[DEPTH-1-k] | acc;
            r[DEPTH-1-k]     = acc;
        end
    end

    assign in_ready  = r[0] & !flush & !reset;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_fire  = out_valid & out_ready;

    always_comb begin : predecessor
        prev_v    = '0;
        prev_v[0] = in_fire;
        prev_d[0] = in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            prev_v[k] = v[k-1];
            prev_d[k] = d[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v         <= '0;
            occupancy <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (r[k]) begin
                    v[k] <= prev_v[k];
                    if (prev_v[k]) begin
                        d[k] <= prev_d[k];
                    end
                end
            end
            if (in_fire && !out_fire) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!in_fire && out_fire) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dff_pipeline.sv
// Bench for dff_pipeline (WIDTH=8, DEPTH=4): directed vector table, corner
// sequences, then random traffic against a beat-position queue model.
module tb_dff_pipeline;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [2:0]   occupancy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dff_pipeline #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    typedef struct {
        logic       rst, fl, iv;
        logic [7:0] din;
        logic       ordy;
        logic       e_ir, e_ov, chk_d;
        logic [7:0] e_od;
        int         e_occ;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         pos;
    } beat_t;

    vec_t  tbl[$];
    beat_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic rst, input logic fl, input logic iv,
                                 input logic [7:0] din, input logic ordy,
                                 input logic e_ir, input logic e_ov, input logic chk_d,
                                 input logic [7:0] e_od, input int e_occ);
        vec_t t;
        t.rst = rst; t.fl = fl; t.iv = iv; t.din = din; t.ordy = ordy;
        t.e_ir = e_ir; t.e_ov = e_ov; t.chk_d = chk_d; t.e_od = e_od; t.e_occ = e_occ;
        return t;
    endfunction

    task automatic apply(input vec_t t, input string tag);
        reset = t.rst; flush = t.fl; in_valid = t.iv; in_data = t.din; out_ready = t.ordy;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(t.e_ir));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(t.e_ov));
        chk({tag, " occupancy"}, 32'(occupancy), 32'(t.e_occ));
        if (t.chk_d) chk({tag, " out_data"}, 32'(out_data), 32'(t.e_od));
    endtask

    initial begin
        logic       rst, fl, iv, ordy, e_ir, fire, ahead_mv, mvb, e_ov;
        logic [7:0] din;
        int         ahead_pos;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;

        // reset held two cycles with traffic present
        tbl.push_back(row(1,0,1,8'hAA,0, 0,0,1,8'h00,0));
        tbl.push_back(row(1,0,1,8'hAA,0, 0,0,1,8'h00,0));
        // streaming 0x01..0x08 with out_ready high
        tbl.push_back(row(0,0,1,8'h01,1, 1,0,0,8'h00,1));
        tbl.push_back(row(0,0,1,8'h02,1, 1,0,0,8'h00,2));
        tbl.push_back(row(0,0,1,8'h03,1, 1,0,0,8'h00,3));
        tbl.push_back(row(0,0,1,8'h04,1, 1,1,1,8'h01,4));
        tbl.push_back(row(0,0,1,8'h05,1, 1,1,1,8'h02,4));
        tbl.push_back(row(0,0,1,8'h06,1, 1,1,1,8'h03,4));
        tbl.push_back(row(0,0,1,8'h07,1, 1,1,1,8'h04,4));
        tbl.push_back(row(0,0,1,8'h08,1, 1,1,1,8'h05,4));
        tbl.push_back(row(0,0,0,8'h00,1, 1,1,1,8'h06,3));
        tbl.push_back(row(0,0,0,8'h00,1, 1,1,1,8'h07,2));
        tbl.push_back(row(0,0,0,8'h00,1, 1,1,1,8'h08,1));
        tbl.push_back(row(0,0,0,8'h00,1, 1,0,0,8'h00,0));
        // backpressure until full, then drain
        tbl.push_back(row(0,0,1,8'h11,0, 1,0,0,8'h00,1));
        tbl.push_back(row(0,0,1,8'h22,0, 1,0,0,8'h00,2));
        tbl.push_back(row(0,0,1,8'h33,0, 1,0,0,8'h00,3));
        tbl.push_back(row(0,0,1,8'h44,0, 1,1,1,8'h11,4));
        tbl.push_back(row(0,0,1,8'h55,0, 0,1,1,8'h11,4));
        tbl.push_back(row(0,0,1,8'h55,0, 0,1,1,8'h11,4));
        tbl.push_back(row(0,0,1,8'h55,1, 1,1,1,8'h22,4));
        tbl.push_back(row(0,0,0,8'h00,1, 1,1,1,8'h33,3));
        tbl.push_back(row(0,0,0,8'h00,1, 1,1,1,8'h44,2));
        tbl.push_back(row(0,0,0,8'h00,1, 1,1,1,8'h55,1));
        tbl.push_back(row(0,0,0,8'h00,1, 1,0,0,8'h00,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // simultaneous in/out while full
        apply(row(0,0,1,8'hC0,0, 1,0,0,8'h00,1), "full fill0");
        apply(row(0,0,1,8'hC1,0, 1,0,0,8'h00,2), "full fill1");
        apply(row(0,0,1,8'hC2,0, 1,0,0,8'h00,3), "full fill2");
        apply(row(0,0,1,8'hC3,0, 1,1,1,8'hC0,4), "full fill3");
        apply(row(0,0,1,8'hC4,1, 1,1,1,8'hC1,4), "full both0");
        apply(row(0,0,1,8'hC5,1, 1,1,1,8'hC2,4), "full both1");
        apply(row(0,0,1,8'hC6,1, 1,1,1,8'hC3,4), "full both2");
        apply(row(0,0,0,8'h00,1, 1,1,1,8'hC4,3), "full drain0");
        apply(row(0,0,0,8'h00,1, 1,1,1,8'hC5,2), "full drain1");
        apply(row(0,0,0,8'h00,1, 1,1,1,8'hC6,1), "full drain2");
        apply(row(0,0,0,8'h00,1, 1,0,0,8'h00,0), "full drain3");

        // bubble collapse: two beats two cycles apart end up adjacent
        apply(row(0,0,1,8'hA0,0, 1,0,0,8'h00,1), "bub0");
        apply(row(0,0,0,8'h00,0, 1,0,0,8'h00,1), "bub1");
        apply(row(0,0,1,8'hA1,0, 1,0,0,8'h00,2), "bub2");
        apply(row(0,0,0,8'h00,0, 1,1,1,8'hA0,2), "bub3");
        apply(row(0,0,0,8'h00,0, 1,1,1,8'hA0,2), "bub4");
        apply(row(0,0,0,8'h00,1, 1,1,1,8'hA1,1), "bub5");
        apply(row(0,0,0,8'h00,1, 1,0,0,8'h00,0), "bub6");

        // flush with three beats held and an input beat offered
        apply(row(0,0,1,8'hE1,0, 1,0,0,8'h00,1), "fl0");
        apply(row(0,0,1,8'hE2,0, 1,0,0,8'h00,2), "fl1");
        apply(row(0,0,1,8'hE3,0, 1,0,0,8'h00,3), "fl2");
        apply(row(0,1,1,8'hEE,0, 0,0,0,8'h00,0), "fl3");
        apply(row(0,0,0,8'h00,1, 1,0,0,8'h00,0), "fl4");
        apply(row(0,0,0,8'h00,1, 1,0,0,8'h00,0), "fl5");
        apply(row(0,0,0,8'h00,1, 1,0,0,8'h00,0), "fl6");
        // flush on an empty pipeline, then reset beats flush
        apply(row(0,1,0,8'h00,0, 0,0,0,8'h00,0), "fl_empty");
        apply(row(0,0,1,8'h5A,0, 1,0,0,8'h00,1), "rst_pri0");
        apply(row(1,1,1,8'h77,1, 0,0,1,8'h00,0), "rst_pri1");

        // random traffic against a queue of beats tagged with stage position
        mq.delete();
        for (int n = 0; n < 800; n++) begin
            rst  = ($urandom_range(0, 39) == 0);
            fl   = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            din  = 8'($urandom);
            ordy = ($urandom_range(0, 9) < 6);
            reset = rst; flush = fl; in_valid = iv; in_data = din; out_ready = ordy;
            #1;
            e_ir = !rst && !fl && (mq.size() < D || ordy);
            chk("rnd in_ready", 32'(in_ready), 32'(e_ir));
            fire = iv && e_ir;
            @(posedge clk);
            #1;
            if (rst || fl) begin
                mq.delete();
            end else begin
                ahead_pos = D;
                ahead_mv  = ordy;
                for (int i = 0; i < mq.size(); i++) begin
                    mvb       = (ahead_pos > mq[i].pos + 1) || ahead_mv;
                    ahead_pos = mq[i].pos;
                    ahead_mv  = mvb;
                    if (mvb) mq[i].pos++;
                end
                if (mq.size() > 0 && mq[0].pos == D) void'(mq.pop_front());
                if (fire) mq.push_back('{data: din, pos: 0});
            end
            e_ov = (mq.size() > 0) && (mq[0].pos == D - 1);
            chk("rnd out_valid", 32'(out_valid), 32'(e_ov));
            chk("rnd occupancy", 32'(occupancy), 32'(mq.size()));
            if (e_ov) chk("rnd out_data", 32'(out_data), 32'(mq[0].data));
            else if (rst) chk("rnd reset out_data", 32'(out_data), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
